// File: rtl/store_buffer_pkg.sv
// Shared types and default widths for the store buffer and its match search.
// Each entry is split into a tag (valid + word address) and the store data.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-3:0] waddr;
    } sb_tag_t;

    typedef struct packed {
        sb_tag_t              tag;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of pipeline-side and memory-side signals of the store buffer.
// slave = store buffer view, master = pipeline/memory environment view.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Handshake: a store is taken on a rising edge when MEM_W_EN=1 and
    // freeze=0; while freeze=1 the pipeline keeps ALU_Res/Rm_Val stable.
    // A drain write is committed on the edge where mem_w_en=1 (mem_ready=1).
    logic              MEM_W_EN;
    logic              MEM_R_EN;
    logic [ADDR_W-1:0] ALU_Res;
    logic [DATA_W-1:0] Rm_Val;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_w_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] MEM_Res;
    logic              fwd_hit;
    logic              freeze;
    logic              empty;
    logic [CNT_W-1:0]  count;

    modport slave (
        input  MEM_W_EN, MEM_R_EN, ALU_Res, Rm_Val, mem_ready, mem_rdata,
        output mem_w_en, mem_addr, mem_wdata, MEM_Res, fwd_hit, freeze, empty, count
    );

    modport master (
        output MEM_W_EN, MEM_R_EN, ALU_Res, Rm_Val, mem_ready, mem_rdata,
        input  mem_w_en, mem_addr, mem_wdata, MEM_Res, fwd_hit, freeze, empty, count
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match search: scans backwards from tail-1 over the live window
// and reports the first valid entry whose word address equals the load's.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  sb_tag_t [DEPTH-1:0] tags,
    input  logic    [PTR_W-1:0] head,
    input  logic    [PTR_W-1:0] tail,
    input  logic [SB_ADDR_W-3:0] waddr,
    output logic                hit,
    output logic    [PTR_W-1:0] idx
);

    localparam int SPAN_W = PTR_W + 1;

    logic [PTR_W-1:0]  span_p;
    logic [SPAN_W-1:0] span;
    logic [PTR_W-1:0]  slot;

    // head==tail means either empty or full; valid bits settle the empty case.
    always_comb begin
        span_p = tail - head;
        span   = (span_p == '0) ? SPAN_W'(DEPTH) : {1'b0, span_p};
    end

    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            slot = tail - PTR_W'(k + 1);
            if (!hit && (SPAN_W'(k) < span) && tags[slot].valid &&
                (tags[slot].waddr == waddr)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Word-granular FIFO store buffer between the MEM stage and single-port memory;
// drains whenever the port is free and forwards the youngest matching store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t [DEPTH-1:0] entries;
    sb_tag_t   [DEPTH-1:0] tags;
    logic [PTR_W-1:0]      head;
    logic [PTR_W-1:0]      tail;
    logic [CNT_W-1:0]      count;

    logic empty;
    logic full;
    logic drain;
    logic accept;
    logic match_hit;
    logic [PTR_W-1:0] match_idx;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tags[i] = entries[i].tag;
        end
    end

    sb_match #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_match (
        .tags  (tags),
        .head  (head),
        .tail  (tail),
        .waddr (bus.ALU_Res[ADDR_W-1:2]),
        .hit   (match_hit),
        .idx   (match_idx)
    );

    // A load owns the memory port, so draining yields to it.
    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign drain  = !empty && bus.mem_ready && !bus.MEM_R_EN;
    assign accept = bus.MEM_W_EN && (!full || drain);

    always_ff @(posedge clk) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            entries <= '0;
        end else begin
            if (drain) begin
                entries[head].tag.valid <= 1'b0;
                head                    <= head + 1'b1;
            end
            // When full, tail==head: this later write overrides the invalidate.
            if (accept) begin
                entries[tail] <= '{tag: '{valid: 1'b1, waddr: bus.ALU_Res[ADDR_W-1:2]},
                                   data: bus.Rm_Val};
                tail          <= tail + 1'b1;
            end
            case ({accept, drain})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign bus.mem_w_en  = drain;
    assign bus.mem_addr  = drain ? {entries[head].tag.waddr, 2'b00} : bus.ALU_Res;
    assign bus.mem_wdata = entries[head].data;
    assign bus.fwd_hit   = bus.MEM_R_EN && match_hit;
    assign bus.MEM_Res   = bus.fwd_hit ? entries[match_idx].data : bus.mem_rdata;
    assign bus.freeze    = bus.MEM_W_EN && !accept;
    assign bus.empty     = empty;
    assign bus.count     = count;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios plus random traffic, all outputs
// compared every cycle with a queue-based model of the buffered stores.
module tb_store_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) sb ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (sb.slave)
    );

    int checks = 0;
    int errors = 0;

    // Pending stores, oldest first.
    logic [DATA_W-1:0] exp_q[$];
    logic [ADDR_W-3:0] exp_addr_q[$];

    bit exp_drain;
    bit exp_accept;
    bit exp_freeze;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and compare every output against the model.
    task automatic step(input bit rst_v, input bit w, input bit r,
                        input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input bit ready, input logic [DATA_W-1:0] rdata);
        int n;
        bit hit;
        logic [DATA_W-1:0] hit_data;
        rst          = rst_v;
        sb.MEM_W_EN  = w;
        sb.MEM_R_EN  = r;
        sb.ALU_Res   = addr;
        sb.Rm_Val    = data;
        sb.mem_ready = ready;
        sb.mem_rdata = rdata;
        #1;
        n          = exp_q.size();
        exp_drain  = (n > 0) && ready && !r;
        exp_accept = w && ((n < DEPTH) || exp_drain);
        exp_freeze = w && !exp_accept;
        hit        = 1'b0;
        hit_data   = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!hit && exp_addr_q[i] == addr[ADDR_W-1:2]) begin
                hit      = 1'b1;
                hit_data = exp_q[i];
            end
        end
        hit = hit && r;
        check("count", sb.count, n);
        check("empty", sb.empty, n == 0);
        check("freeze", sb.freeze, exp_freeze);
        check("mem_w_en", sb.mem_w_en, exp_drain);
        check("mem_addr", sb.mem_addr, exp_drain ? {exp_addr_q[0], 2'b00} : addr);
        if (exp_drain) check("mem_wdata", sb.mem_wdata, exp_q[0]);
        check("fwd_hit", sb.fwd_hit, hit);
        check("MEM_Res", sb.MEM_Res, hit ? hit_data : rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            exp_q.delete();
            exp_addr_q.delete();
        end else begin
            if (exp_drain) begin
                void'(exp_q.pop_front());
                void'(exp_addr_q.pop_front());
            end
            if (exp_accept) begin
                exp_q.push_back(sb.Rm_Val);
                exp_addr_q.push_back(sb.ALU_Res[ADDR_W-1:2]);
            end
        end
        #1;
    endtask

    initial begin
        bit hold_w;
        logic [ADDR_W-1:0] hold_a;
        logic [DATA_W-1:0] hold_d;
        sb.MEM_W_EN  = 1'b0;
        sb.MEM_R_EN  = 1'b0;
        sb.ALU_Res   = '0;
        sb.Rm_Val    = '0;
        sb.mem_ready = 1'b0;
        sb.mem_rdata = '0;
        rst          = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle; load falls through to memory.
        step(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        check("rst_empty", sb.empty, 1);
        check("rst_freeze", sb.freeze, 0);
        tick();
        step(1, 0, 1, 32'h400, 32'h0, 1, 32'h55);
        check("idle_load_res", sb.MEM_Res, 32'h55);
        check("idle_load_hit", sb.fwd_hit, 0);
        tick();

        // Two stores held back, then a forwarded load.
        step(1, 1, 0, 32'h400, 32'hA, 0, 32'h0); tick();
        step(1, 1, 0, 32'h404, 32'hB, 0, 32'h0); tick();
        step(1, 0, 1, 32'h400, 32'h0, 1, 32'h77);
        check("fwd_count", sb.count, 2);
        check("fwd_hit", sb.fwd_hit, 1);
        check("fwd_res", sb.MEM_Res, 32'hA);
        check("fwd_no_drain", sb.mem_w_en, 0);
        tick();

        // Same word stored twice; youngest wins, low address bits ignored.
        step(1, 1, 0, 32'h408, 32'h1, 0, 32'h0); tick();
        step(1, 1, 0, 32'h408, 32'h2, 0, 32'h0); tick();
        step(1, 0, 1, 32'h40B, 32'h0, 0, 32'h33);
        check("youngest_res", sb.MEM_Res, 32'h2);
        tick();
        repeat (DEPTH) begin step(1, 0, 0, 32'h0, 32'h0, 1, 32'h0); tick(); end

        // Overfill with memory busy, then release in the freezing cycle.
        for (int i = 0; i <= DEPTH; i++) begin
            step(1, 1, 0, 32'h500 + 4 * i, 32'h100 + i, 0, 32'h0);
            if (i == DEPTH) begin
                check("full_freeze", sb.freeze, 1);
                check("full_count", sb.count, DEPTH);
            end
            tick();
        end
        step(1, 1, 0, 32'h500 + 4 * DEPTH, 32'h100 + DEPTH, 1, 32'h0);
        check("full_accept_freeze", sb.freeze, 0);
        check("full_accept_addr", sb.mem_addr, 32'h500);
        check("full_accept_wdata", sb.mem_wdata, 32'h100);
        tick();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
            if (i == 1) check("full_count_kept", sb.count, DEPTH);
            check("drain_addr", sb.mem_addr, 32'h500 + 4 * i);
            check("drain_wdata", sb.mem_wdata, 32'h100 + i);
            tick();
        end
        // Pointers wrap with another round.
        for (int i = 0; i < DEPTH; i++) begin step(1, 1, 0, 32'h600 + 4 * i, 32'h200 + i, 0, 32'h0); tick(); end
        repeat (DEPTH + 1) begin step(1, 0, 0, 32'h0, 32'h0, 1, 32'h0); tick(); end

        // Reset while frozen discards everything.
        for (int i = 0; i < DEPTH; i++) begin step(1, 1, 0, 32'h700 + 4 * i, 32'h300 + i, 0, 32'h0); tick(); end
        step(0, 1, 0, 32'h710, 32'h3FF, 0, 32'h0);
        check("rst_mid_freeze", sb.freeze, 1);
        tick();
        step(1, 0, 0, 32'h0, 32'h0, 1, 32'h0);
        check("post_rst_count", sb.count, 0);
        check("post_rst_empty", sb.empty, 1);
        check("post_rst_wen", sb.mem_w_en, 0);
        tick();
        step(1, 0, 1, 32'h700, 32'h0, 1, 32'h99);
        check("post_rst_load", sb.MEM_Res, 32'h99);
        tick();

        // Random traffic; a frozen store is held until taken.
        hold_w = 1'b0;
        hold_a = '0;
        hold_d = '0;
        for (int c = 0; c < 600; c++) begin
            bit rv, w, r, rdy;
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            int op;
            rv  = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            op  = $urandom_range(0, 3);
            a   = 32'h800 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
            d   = $urandom;
            w   = (op == 1) || (op == 3);
            r   = (op == 2);
            if (hold_w) begin
                w = 1'b1; r = 1'b0; a = hold_a; d = hold_d;
            end
            step(rv, w, r, a, d, rdy, $urandom);
            hold_w = exp_freeze && rv;
            hold_a = a;
            hold_d = d;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
